hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core; the stall/flush counterpart to the forwarding unit.
- The forwarding unit bypasses producer results forward. This block holds consumers back when no bypass can help:
  - load-use hazards
  - multi-cycle MUL/DIV occupying EX
- It also squashes wrong-path instructions on a taken branch.
- It drives the PC and pipeline-register write enables, flushes and bubbles, and keeps a stall-cycle performance counter.

Parameters:
- MULDIV_LAT, 4, total cycles a MUL/DIV instruction occupies EX (legal range 2..16).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- IF_IDRs1  input  5  rs1 of the instruction in ID
- IF_IDRs2  input  5  rs2 of the instruction in ID
- ID_EXRegRd  input  5  rd of the instruction in EX
- ID_EXMemRead  input  1  instruction in EX is a load
- ID_EXMulDiv  input  1  instruction in EX is MUL/DIV
- BranchTaken  input  1  branch/jump in EX resolved taken
- PC_Write  output  1  PC update enable
- IF_IDWrite  output  1  IF/ID register load enable
- ID_EXWrite  output  1  ID/EX register load enable
- IF_IDFlush  output  1  clear IF/ID to NOP
- ID_EXFlush  output  1  load bubble into ID/EX
- EX_MEMBubble  output  1  load bubble into EX/MEM
- MD_Busy  output  1  MUL/DIV stall in progress
- Stall_Cnt  output  CNT_W  cycles with PC_Write=0, saturating

Behaviour:
- Reset: state is RUN; md_cnt=0; Stall_Cnt=0.
- While rst=1, outputs are forced as follows:
  - PC_Write=1, IF_IDWrite=1, ID_EXWrite=1
  - all flush/bubble outputs 0; MD_Busy=0
- Reset mid-operation (any state) returns to RUN on the next edge.
- Outputs are combinational from the current state and inputs (zero-cycle latency). State and counters are registered.
- Default (no hazard): PC_Write=1, IF_IDWrite=1, ID_EXWrite=1, flushes 0.
- Load-use hazard condition: ID_EXMemRead && ID_EXRegRd!=0 && (ID_EXRegRd==IF_IDRs1 || ID_EXRegRd==IF_IDRs2).
  - Response: PC_Write=0, IF_IDWrite=0, ID_EXFlush=1, for exactly one cycle.
  - The next cycle sees the bubble in EX, so no repeat occurs.
- Taken branch (BranchTaken=1): IF_IDFlush=1, ID_EXFlush=1, PC_Write=1.
  - Branch has priority over load-use, because the consumer is squashed.
- MD stall outputs: PC_Write=0, IF_IDWrite=0, ID_EXWrite=0, EX_MEMBubble=1, MD_Busy=1.
  - Load-use and BranchTaken are ignored while these are active.
- FSM states: RUN, MD_BUSY, MD_DONE.
  - RUN, ID_EXMulDiv=1: MD stall outputs. Next state is MD_DONE if MULDIV_LAT==2, else MD_BUSY with md_cnt<=MULDIV_LAT-3.
  - RUN, otherwise: branch/load-use rules; stay in RUN.
  - MD_BUSY: MD stall outputs. If md_cnt==0, go to MD_DONE; else md_cnt decrements.
  - MD_DONE: ID_EXMulDiv is ignored (same held instruction completes and advances). Branch/load-use rules apply. Next state is RUN.
- MUL/DIV therefore stalls exactly MULDIV_LAT-1 cycles; its result enters EX/MEM in the MD_DONE cycle.
- BranchTaken together with ID_EXMulDiv in RUN is an illegal combination. MUL/DIV wins and BranchTaken is dropped; the RTL carries a simulation assertion for it.
- Stall_Cnt increments in every non-reset cycle with PC_Write=0 and saturates at all ones. Branch flush cycles are not counted.

Decomposition:
- Shared package (hazard_pkg) holds:
  - state enum {RUN, MD_BUSY, MD_DONE}
  - REG_X0 constant (5'd0)
  - MULDIV_LAT range check constants
- One sub-module: sat_counter (CNT_W-bit enable-driven saturating counter with sync reset), used for Stall_Cnt.
- The FSM and hazard compare logic stay in the top module.

Test Plan:
- Load-use, ID_EXMemRead=1, ID_EXRegRd=5, IF_IDRs1=5, IF_IDRs2=7:
  - PC_Write=0, IF_IDWrite=0, ID_EXFlush=1 for 1 cycle.
  - Next cycle with ID_EXMemRead=0: all defaults. Stall_Cnt=1.
- x0 and rs2 cases:
  - ID_EXMemRead=1, ID_EXRegRd=0, IF_IDRs1=0 -> no stall.
  - Repeat with ID_EXRegRd=9, IF_IDRs2=9 -> one-cycle stall.
- Priority, BranchTaken=1 together with a load-use match on rs1 -> IF_IDFlush=1, ID_EXFlush=1, PC_Write=1, Stall_Cnt unchanged.
- MULDIV_LAT=4, ID_EXMulDiv held 1 -> MD stall outputs for exactly 3 cycles, then one MD_DONE cycle with defaults, then RUN. Stall_Cnt=3.
- MULDIV_LAT=2 -> exactly 1 stall cycle, then MD_DONE (ID_EXMulDiv=1 ignored), then RUN.
- Reset mid-MD_BUSY, rst=1 on the second stall cycle:
  - Outputs forced to defaults immediately.
  - After rst drops: state RUN, Stall_Cnt=0.
  - A new ID_EXMulDiv pulse restarts the full 3-cycle stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard stall/flush controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN,
      MD_BUSY,
      MD_DONE
   } state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   // Legal MUL/DIV occupancy of EX and the down-counter width that covers it.
   localparam int MULDIV_LAT_MIN = 2;
   localparam int MULDIV_LAT_MAX = 16;
   localparam int MD_CNT_W       = 4;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Enable-driven up counter that sticks at all ones instead of wrapping.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignment so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller: load-use interlock, multi-cycle MUL/DIV hold and
// taken-branch squash, plus a saturating count of cycles with the PC frozen.
module hazard_stall_ctrl
   import hazard_pkg::*;
#(
   parameter int MULDIV_LAT = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IF_IDRs1,
   input  logic [4:0]       IF_IDRs2,
   input  logic [4:0]       ID_EXRegRd,
   input  logic             ID_EXMemRead,
   input  logic             ID_EXMulDiv,
   input  logic             BranchTaken,
   output logic             PC_Write,
   output logic             IF_IDWrite,
   output logic             ID_EXWrite,
   output logic             IF_IDFlush,
   output logic             ID_EXFlush,
   output logic             EX_MEMBubble,
   output logic             MD_Busy,
   output logic [CNT_W-1:0] Stall_Cnt
);

   // The RUN cycle and the MD_DONE cycle account for two of the MULDIV_LAT
   // cycles, so MD_BUSY lasts MULDIV_LAT-2 cycles (counter loads LAT-3).
   localparam logic [MD_CNT_W-1:0] MD_CNT_INIT =
      (MULDIV_LAT > 2) ? MD_CNT_W'(MULDIV_LAT - 3) : '0;

   state_t              state, state_nxt;
   logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
   logic                load_use;

   assign load_use = ID_EXMemRead && (ID_EXRegRd != REG_X0) &&
                     ((ID_EXRegRd == IF_IDRs1) || (ID_EXRegRd == IF_IDRs2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   // NOTE: every output is given a default before the case so no path through
   // this block leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt    = state;
      md_cnt_nxt   = md_cnt;
      PC_Write     = 1'b1;
      IF_IDWrite   = 1'b1;
      ID_EXWrite   = 1'b1;
      IF_IDFlush   = 1'b0;
      ID_EXFlush   = 1'b0;
      EX_MEMBubble = 1'b0;
      MD_Busy      = 1'b0;

      if (!rst) begin
         if ((state == MD_BUSY) || ((state == RUN) && ID_EXMulDiv)) begin
            PC_Write     = 1'b0;
            IF_IDWrite   = 1'b0;
            ID_EXWrite   = 1'b0;
            EX_MEMBubble = 1'b1;
            MD_Busy      = 1'b1;
         end else if (BranchTaken) begin
            IF_IDFlush = 1'b1;
            ID_EXFlush = 1'b1;
         end else if (load_use) begin
            PC_Write   = 1'b0;
            IF_IDWrite = 1'b0;
            ID_EXFlush = 1'b1;
         end

         unique case (state)
            RUN: begin
               if (ID_EXMulDiv) begin
                  state_nxt  = (MULDIV_LAT == 2) ? MD_DONE : MD_BUSY;
                  md_cnt_nxt = MD_CNT_INIT;
               end
            end
            MD_BUSY: begin
               if (md_cnt == '0) state_nxt = MD_DONE;
               else              md_cnt_nxt = md_cnt - 1'b1;
            end
            MD_DONE: state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (!PC_Write),
      .count (Stall_Cnt)
   );

   // A branch resolving alongside a fresh MUL/DIV in EX cannot happen in a
   // well-formed pipeline; the MUL/DIV hold wins if it ever does.
   always_ff @(posedge clk) begin
      assert ((MULDIV_LAT >= MULDIV_LAT_MIN) && (MULDIV_LAT <= MULDIV_LAT_MAX))
         else $error("hazard_stall_ctrl: MULDIV_LAT %0d out of range", MULDIV_LAT);
      if (!rst && (state == RUN))
         assert (!(ID_EXMulDiv && BranchTaken))
            else $error("hazard_stall_ctrl: BranchTaken with ID_EXMulDiv in RUN");
   end

endmodule
